pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK (STAGES = WIDTH/CHUNK).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands present.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have ports in_a, in_b  input  WIDTH  operands.
REQ-008 SHALL have port in_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_sum  output  WIDTH  result modulo 2^WIDTH.
REQ-012 SHALL have port out_carry  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-013 SHALL have port out_ovf  output  1  two's-complement signed overflow.

Function
REQ-014 Stage k (0..STAGES-1) SHALL add bits [k*CHUNK +: CHUNK] of A and B (B inverted when subtracting) plus the carry registered by stage k-1; stage 0 carry-in SHALL be in_sub.
REQ-015 Operand bits not yet consumed, in_sub and partial sum bits SHALL travel with each stage's valid bit (skewed pipeline); no combinational carry path SHALL span more than CHUNK bits.
REQ-016 Latency SHALL be exactly STAGES cycles from input handshake to out_valid with out_ready held high; STAGES=1 gives latency 1.
REQ-017 Throughput SHALL be one operation per cycle with out_ready high; bubbles SHALL propagate as invalid stages.
REQ-018 Input handshake occurs when in_valid && in_ready; output handshake when out_valid && out_ready.
REQ-019 in_ready SHALL equal !out_valid || out_ready; when in_ready is low the whole pipeline SHALL hold (global stall).
REQ-020 While out_valid && !out_ready, out_sum, out_carry, out_ovf SHALL remain stable.
REQ-021 out_ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-022 Results SHALL emerge in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-023 in_valid low while in_ready high SHALL insert a bubble; in_valid/operands while in_ready low SHALL be ignored.

Reset
REQ-024 rst_n low SHALL asynchronously clear all stage valid bits; out_valid = 0, out_sum = 0, out_carry = 0, out_ovf = 0.
REQ-025 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-026 Datapath registers other than outputs need not be reset.

Structure
REQ-027 Shared package adder_pkg SHALL hold the op encoding constants (OP_ADD = 0, OP_SUB = 1) and the STAGES derivation.
REQ-028 One sub-module chunk_adder SHALL implement a CHUNK-bit ripple slice (a, b, cin -> sum, cout, carry into MSB), instantiated once per stage via generate.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-029 Add 0xFF + 0x01, out_ready=1 -> after 2 cycles out_sum=0x00, out_carry=1, out_ovf=0.
REQ-030 Add 0x7F + 0x01 -> out_sum=0x80, out_carry=0, out_ovf=1; sub 0x80 - 0x01 -> out_sum=0x7F, out_carry=1, out_ovf=1.
REQ-031 Sub 0x00 - 0x01 -> out_sum=0xFF, out_carry=0, out_ovf=0.
REQ-032 Stream 16 back-to-back random ops with out_ready toggled randomly -> all 16 results in order, match reference model, outputs stable during stall.
REQ-033 Assert rst_n low with 2 ops in flight -> out_valid=0 immediately, no stale result after release.
REQ-034 WIDTH=8, CHUNK=8: 0x12 + 0x34 -> out_sum=0x46 one cycle after acceptance.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder.
//   OP_ADD / OP_SUB : encoding of the in_sub operand-select bit
//   calc_stages()   : number of pipeline stages for a WIDTH / CHUNK split
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry slice, one per pipeline stage.
//   a, b  : slice operands (b already inverted by the caller for subtract)
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (feeds signed-overflow detection)
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Skewed carry-pipelined adder/subtractor with valid/ready handshakes.
// Stage k adds bits [k*CHUNK +: CHUNK]; operands, op select and the partial
// sum ride along with each stage's valid bit, so no carry chain exceeds
// CHUNK bits. A single in_ready stalls the whole pipe when the output is
// blocked.
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (in_a, in_b, in_sub)
//   out_valid / out_ready : result handshake (out_sum, out_carry, out_ovf)
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    // Stage registers; index k holds the state after chunk k has been added.
    logic [STAGES-1:0]            vld_q,  vld_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q,    a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q,    b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q,  sum_d;
    logic [STAGES-1:0]            sub_q,  sub_d;
    logic [STAGES-1:0]            cy_q,   cy_d;
    logic [STAGES-1:0]            ovf_q,  ovf_d;

    // What each stage sees on its input side: the ports for stage 0,
    // the previous stage's registers otherwise.
    logic [STAGES-1:0]            vld_src;
    logic [STAGES-1:0][WIDTH-1:0] a_src;
    logic [STAGES-1:0][WIDTH-1:0] b_src;
    logic [STAGES-1:0][WIDTH-1:0] sum_src;
    logic [STAGES-1:0]            sub_src;
    logic [STAGES-1:0]            cin_src;

    logic [STAGES-1:0][CHUNK-1:0] chunk_sum;
    logic [STAGES-1:0]            chunk_cout;
    logic [STAGES-1:0]            chunk_cmsb;

    assign out_valid = vld_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_carry = cy_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];

    // Global stall: everything advances together or nothing moves.
    assign in_ready  = !out_valid || out_ready;

    always_comb begin
        vld_src    = '0;
        a_src      = '0;
        b_src      = '0;
        sum_src    = '0;
        sub_src    = '0;
        cin_src    = '0;
        vld_src[0] = in_valid;
        a_src[0]   = in_a;
        b_src[0]   = in_b;
        sub_src[0] = (in_sub == OP_SUB);
        cin_src[0] = (in_sub == OP_SUB);   // +1 of the two's-complement negate
        for (int k = 1; k < STAGES; k++) begin
            vld_src[k] = vld_q[k-1];
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            sum_src[k] = sum_q[k-1];
            sub_src[k] = sub_q[k-1];
            cin_src[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] b_slice;

        assign b_slice = b_src[k][k*CHUNK +: CHUNK] ^ {CHUNK{sub_src[k]}};

        chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a    (a_src[k][k*CHUNK +: CHUNK]),
            .b    (b_slice),
            .cin  (cin_src[k]),
            .sum  (chunk_sum[k]),
            .cout (chunk_cout[k]),
            .cmsb (chunk_cmsb[k])
        );
    end

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        sum_d = sum_q;
        sub_d = sub_q;
        cy_d  = cy_q;
        ovf_d = ovf_q;
        if (in_ready) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_d[k] = vld_src[k];
                a_d[k]   = a_src[k];
                b_d[k]   = b_src[k];
                sub_d[k] = sub_src[k];
                sum_d[k] = sum_src[k];
                sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[k];
                cy_d[k]  = chunk_cout[k];
                // Only the last stage's value reaches out_ovf; there it is
                // carry-into-MSB XOR carry-out-of-MSB of the full word.
                ovf_d[k] = chunk_cmsb[k] ^ chunk_cout[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            sub_q <= '0;
            cy_q  <= '0;
            ovf_q <= '0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            sum_q <= sum_d;
            sub_q <= sub_d;
            cy_q  <= cy_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed + randomized bench for pipe_adder (8/4 instance) plus a
// single-stage 8/8 instance. Reference results come from signed/unsigned
// integer arithmetic on the operands.
module tb_pipe_adder;

    localparam int WIDTH  = 8;
    localparam int CHUNK  = 4;
    localparam int STAGES = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_sub;
    logic [WIDTH-1:0] in_a, in_b;
    logic             out_valid, out_ready, out_carry, out_ovf;
    logic [WIDTH-1:0] out_sum;

    logic       v8, r8, s8, rdy8, ov8, c8, o8;
    logic [7:0] a8, b8, sum8;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
    );

    pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8), .in_sub(s8),
        .out_valid(ov8), .out_ready(r8),
        .out_sum(sum8), .out_carry(c8), .out_ovf(o8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, carry, sum}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int ur, sr;
        logic c, o;
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur > 255);
        end
        o = (sr > 127) || (sr < -128);
        return {o, c, ur[7:0]};
    endfunction

    task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"},   lat,       STAGES);
        chk({tag, "_sum"},   out_sum,   es);
        chk({tag, "_carry"}, out_carry, ec);
        chk({tag, "_ovf"},   out_ovf,   eo);
    endtask

    task automatic run_stream(input int n, input bit bubbles);
        logic [9:0] exp_q[$];
        logic [9:0] held, e;
        int  sent = 0, got = 0, cyc = 0;
        bit  stall_prev = 1'b0;
        while (got < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                chk("hold_vld",  out_valid, 1);
                chk("hold_data", {out_ovf, out_carry, out_sum}, held);
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < n) && (!bubbles || ($urandom_range(0, 3) != 0));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_sub    = 1'($urandom_range(0, 1));
            #1;
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("stream_res", {out_ovf, out_carry, out_sum}, e);
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_sub));
                sent++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_ovf, out_carry, out_sum};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_cnt", got, n);
        chk("stream_left", exp_q.size(), 0);
        repeat (3) begin
            @(negedge clk);
            chk("stream_dup", out_valid, 0);
        end
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; r8 = 1'b1;
        #3;
        chk("rst_vld",   out_valid, 0);
        chk("rst_sum",   out_sum,   0);
        chk("rst_carry", out_carry, 0);
        chk("rst_ovf",   out_ovf,   0);
        chk("rst_ready", in_ready,  1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        single("ff_p_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        single("7f_p_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        single("80_m_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        single("00_m_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);

        run_stream(16, 1'b0);
        run_stream(20, 1'b1);

        // Two operations in flight, then an asynchronous reset mid-cycle.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_sub = 1'b0;
        @(negedge clk);
        in_a = 8'h33; in_b = 8'h44;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_vld", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld",   out_valid, 0);
        chk("arst_sum",   out_sum,   0);
        chk("arst_carry", out_carry, 0);
        chk("arst_ovf",   out_ovf,   0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end

        // Single-stage instance: latency of one cycle.
        @(negedge clk);
        v8 = 1'b1; a8 = 8'h12; b8 = 8'h34; s8 = 1'b0;
        @(negedge clk);
        v8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk("c8_lat",   lat,  1);
        chk("c8_sum",   sum8, 8'h46);
        chk("c8_carry", c8,   0);
        chk("c8_ovf",   o8,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
